puf_soc_sipo: RTL
=================

Name: puf_soc_sipo

Overview:
- Serial-in parallel-out deserializer. Sits directly downstream of the PUF SoC serializer, on the receive side of the serial link.
- Collects an LSB-first bit stream into a normal (NORM_MOD bits) or debug (DEBUG_MOD bits) frame.
- Presents each completed frame on a parallel valid/ready interface.
- Double-buffered: a new frame can be collected while the previous one waits to be consumed. Also provides inter-bit gap timeout and overrun detection.

Parameters:
- FRAM_SIZE, 160, width of the parallel output frame.
- NORM_MOD, 34, bits per normal-mode frame (2..FRAM_SIZE).
- DEBUG_MOD, 133, bits per debug-mode frame (2..FRAM_SIZE).
- GAP_TIMEOUT, 16, maximum idle cycles between bits inside a frame before abort (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_rx_en  in  1  1: receiver enabled; 0: idle, partial frame aborted.
- i_rx_mode  in  1  1: debug frame (DEBUG_MOD bits), 0: normal frame (NORM_MOD bits); sampled on first bit.
- i_rx_data  in  1  serial data bit.
- i_rx_valid  in  1  i_rx_data valid this cycle.
- i_rx_ready  in  1  downstream accepts o_rx_data this cycle.
- o_rx_data  out  FRAM_SIZE  completed frame; bit k = k-th received bit, bits >= N are zero.
- o_rx_len  out  $clog2(FRAM_SIZE+1)  bit count N of the frame on o_rx_data.
- o_rx_valid  out  1  o_rx_data/o_rx_len valid.
- o_rx_busy  out  1  1 while a frame is being collected.
- o_rx_overrun  out  1  one-cycle pulse: a completed frame was dropped.
- o_rx_abort  out  1  one-cycle pulse: a partial frame was discarded (timeout or disable).

Behaviour:
- Reset (asynchronous, all state):
  - FSM = IDLE; shift buffer, o_rx_data, o_rx_len and all counters cleared.
  - o_rx_valid, o_rx_busy, o_rx_overrun and o_rx_abort = 0.
- Frame length: N = latched_mode ? DEBUG_MOD : NORM_MOD. Mode is latched with bit 0 and ignored for the rest of the frame.
- FSM states: IDLE, COLLECT.
- IDLE:
  - On i_rx_en & i_rx_valid: store bit at index 0, bit_cnt = 1, gap_cnt = 0, latch mode, go to COLLECT.
  - i_rx_valid with i_rx_en = 0 is ignored.
- COLLECT (o_rx_busy = 1):
  - On i_rx_valid: store bit at index bit_cnt, bit_cnt++, gap_cnt = 0.
  - Without i_rx_valid: gap_cnt++.
- Completion: the cycle the bit at index N-1 is stored, the frame is complete.
  - Next cycle: FSM = IDLE, bit_cnt = 0, collection buffer cleared.
  - Transfer of the frame to the output register follows the output handshake rules below.
- Output handshake:
  - Latency: o_rx_valid rises the cycle after the last bit's valid cycle.
  - o_rx_data, o_rx_len and o_rx_valid are held stable until o_rx_valid & i_rx_ready.
  - o_rx_valid clears the cycle after acceptance, unless a new frame is loaded that same edge.
- Simultaneous accept and completion (o_rx_valid & i_rx_ready in the same cycle the last bit is stored): the new frame is loaded, o_rx_valid stays 1, no overrun.
- Overrun (completion while o_rx_valid = 1 and i_rx_ready = 0):
  - New frame dropped; output register unchanged.
  - o_rx_overrun pulses 1 cycle; FSM returns to IDLE.
- Gap timeout: in COLLECT, when gap_cnt reaches GAP_TIMEOUT:
  - Partial frame discarded, o_rx_abort pulses 1 cycle, go to IDLE.
  - The output register is unaffected.
- Disable: i_rx_en = 0 while in COLLECT:
  - Same abort action next edge. A bit presented that cycle is not stored.
  - The output register and its handshake continue regardless of i_rx_en.
- No wrap: bit_cnt never exceeds N-1 at a write; bits arriving in IDLE start a new frame.
- A valid bit in the cycle after completion starts the next frame (back-to-back frames, zero gap).

Test Plan:
- Normal frame: mode=0, 34 valid bits of 0x2_A5A5_A5A5 LSB first, i_rx_ready=1 -> o_rx_valid high 1 cycle after bit 33, o_rx_data=0x2A5A5A5A5, o_rx_len=34, upper bits 0.
- Debug frame: mode=1 at bit 0 (then toggled to 0 mid-frame), 133 bits alternating 1,0 -> o_rx_len=133, o_rx_data[132:0]=...0101 with bit0=1; the mode toggle has no effect.
- Backpressure/overrun: i_rx_ready=0, two normal frames back-to-back -> first frame held, o_rx_overrun pulse 1 cycle after frame 2's last bit, o_rx_data still frame 1; then ready=1 -> frame 1 accepted, o_rx_valid drops.
- Simultaneous: frame 1 pending, i_rx_ready=1 in the exact cycle frame 2's last bit arrives -> no overrun, o_rx_valid stays 1, o_rx_data=frame 2 next cycle.
- Gap timeout/disable: 10 bits then 16 idle cycles -> o_rx_abort pulse, o_rx_busy=0, next 34 bits form a correct frame. Repeat with i_rx_en dropped at bit 5 -> abort pulse, no o_rx_valid.
- Reset mid-frame: assert rst_n=0 asynchronously at bit 20 with a pending output frame -> all outputs 0 immediately; after release, a fresh 34-bit frame is received correctly.

Source files
------------

// File: rtl/puf_soc_sipo.sv
`default_nettype none
// ============================================================================
// puf_soc_sipo : LSB-first serial-to-parallel frame deserializer that presents
// each completed frame on a double-buffered valid/ready output register.
// Revision: 1.0
// ============================================================================
module puf_soc_sipo #(
    parameter int FRAM_SIZE   = 160,
    parameter int NORM_MOD    = 34,
    parameter int DEBUG_MOD   = 133,
    parameter int GAP_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_rx_en,
    input  logic                           i_rx_mode,
    input  logic                           i_rx_data,
    input  logic                           i_rx_valid,
    input  logic                           i_rx_ready,
    output logic [FRAM_SIZE-1:0]           o_rx_data,
    output logic [$clog2(FRAM_SIZE+1)-1:0] o_rx_len,
    output logic                           o_rx_valid,
    output logic                           o_rx_busy,
    output logic                           o_rx_overrun,
    output logic                           o_rx_abort
);

    localparam int LEN_W = $clog2(FRAM_SIZE + 1);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    localparam logic [LEN_W-1:0] NORM_LEN   = LEN_W'(NORM_MOD);
    localparam logic [LEN_W-1:0] DEBUG_LEN  = LEN_W'(DEBUG_MOD);
    localparam logic [LEN_W-1:0] NORM_LAST  = LEN_W'(NORM_MOD - 1);
    localparam logic [LEN_W-1:0] DEBUG_LAST = LEN_W'(DEBUG_MOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [FRAM_SIZE-1:0]   shift_buf;
    logic [LEN_W-1:0]       bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   mode;

    logic                   start;
    logic                   store;
    logic                   complete;
    logic                   abort;
    logic                   load;
    logic                   overrun;
    logic [LEN_W-1:0]       frame_len;
    logic [FRAM_SIZE-1:0]   frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        store     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_en && i_rx_valid) begin
                    start     = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                // Disable wins over a bit presented in the same cycle.
                if (!i_rx_en) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (i_rx_valid) begin
                    store = 1'b1;
                    if (bit_cnt == (mode ? DEBUG_LAST : NORM_LAST)) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign frame_len = mode ? DEBUG_LEN : NORM_LEN;
    assign frame     = shift_buf | (FRAM_SIZE'(i_rx_data) << bit_cnt);
    assign load      = complete && (!o_rx_valid || i_rx_ready);
    assign overrun   = complete && o_rx_valid && !i_rx_ready;
    assign o_rx_busy = (state == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_buf <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            mode      <= 1'b0;
        end else if (start) begin
            shift_buf <= FRAM_SIZE'(i_rx_data);
            bit_cnt   <= LEN_W'(1);
            gap_cnt   <= '0;
            mode      <= i_rx_mode;
        end else if (complete || abort) begin
            shift_buf <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else if (store) begin
            shift_buf <= frame;
            bit_cnt   <= bit_cnt + 1'b1;
            gap_cnt   <= '0;
        end else if (state == COLLECT) begin
            gap_cnt   <= gap_cnt + 1'b1;
        end
    end

    // Output register: loaded on completion only if empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_data    <= '0;
            o_rx_len     <= '0;
            o_rx_valid   <= 1'b0;
            o_rx_overrun <= 1'b0;
            o_rx_abort   <= 1'b0;
        end else begin
            o_rx_overrun <= overrun;
            o_rx_abort   <= abort;
            if (load) begin
                o_rx_data  <= frame;
                o_rx_len   <= frame_len;
                o_rx_valid <= 1'b1;
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
